// File: rtl/input_spi.sv
// Pulse-width line-code receiver: decodes 3-cell symbols into FRAME_BITS-wide bytes behind a valid/ready holding register.
// Optional `INPUT_SPI_SYNC_EN adds a 2-flop synchronizer on din and en_in.
module input_spi #(
   parameter int FRAME_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   input  logic                  en_in,
   output logic [FRAME_BITS-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_C1,
      S_C2,
      S_C0
   } state_t;

   logic din_s;
   logic en_s;

`ifdef INPUT_SPI_SYNC_EN
   logic [1:0] din_sync_q;
   logic [1:0] en_sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         din_sync_q <= 2'b00;
         en_sync_q  <= 2'b00;
      end else begin
         din_sync_q <= {din_sync_q[0], din};
         en_sync_q  <= {en_sync_q[0], en_in};
      end
   end

   assign din_s = din_sync_q[1];
   assign en_s  = en_sync_q[1];
`else
   assign din_s = din;
   assign en_s  = en_in;
`endif

   state_t                  state_q;
   logic [CNT_W-1:0]        bit_cnt_q;
   logic [FRAME_BITS-1:0]   sr_q;
   logic                    bit_q;
   logic [FRAME_BITS-1:0]   dout_q;
   logic                    dout_valid_q;
   logic                    frame_err_q;
   logic                    overrun_q;

   logic [FRAME_BITS:0]     sr_ext;
   logic [FRAME_BITS-1:0]   sr_d;
   logic                    frame_viol;
   logic                    frame_done;
   logic                    accept;

   // New bit enters at the MSB so that after FRAME_BITS shifts the first (LSB) bit sits at bit 0.
   assign sr_ext = {bit_q, sr_q};
   assign sr_d   = sr_ext[FRAME_BITS:1];

   assign frame_viol = ((state_q == S_C1) && !en_s) ||
                       ((state_q == S_C2) && (!en_s || din_s)) ||
                       ((state_q == S_C0) && !(en_s && din_s));
   assign frame_done = (state_q == S_C2) && en_s && !din_s && (bit_cnt_q == LAST_BIT);
   assign accept     = dout_valid_q && dout_ready;

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         sr_q         <= '0;
         bit_q        <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_err_q <= frame_viol;

         if (frame_viol) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  bit_cnt_q <= '0;
                  if (en_s && din_s) state_q <= S_C1;
               end
               S_C1: begin
                  bit_q   <= din_s;
                  state_q <= S_C2;
               end
               S_C2: begin
                  sr_q <= sr_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= S_IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     state_q   <= S_C0;
                  end
               end
               S_C0:    state_q <= S_C1;
               default: state_q <= S_IDLE;
            endcase
         end

         // A completed byte may reuse the holding register on the same edge it is drained.
         if (frame_done) begin
            if (!dout_valid_q || dout_ready) begin
               dout_q       <= sr_d;
               dout_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (accept) begin
            dout_valid_q <= 1'b0;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule
